// File: rtl/i2c_master_arbiter_if.sv
// Bundle between the client requesters, the I2C master core and the arbiter.
// slave = arbiter side, master = the environment (clients plus I2C master core).
interface i2c_master_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 7,
  parameter int DW   = 8
);
  // Handshake: req is a level held until that requester's one-cycle done pulse;
  // m_start and m_abort are one-cycle strobes, m_done is a one-cycle pulse with
  // m_nack/m_rdata valid in the same cycle, and rdata/err_* are valid only with done.
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    req_rw;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [DW-1:0]      rdata;
  logic               err_nack;
  logic               err_tmo;
  logic               m_start;
  logic [AW-1:0]      m_addr;
  logic               m_rw;
  logic [DW-1:0]      m_wdata;
  logic               m_abort;
  logic               m_busy;
  logic               m_done;
  logic               m_nack;
  logic [DW-1:0]      m_rdata;

  modport slave (
    input  req, req_addr, req_rw, req_wdata, m_busy, m_done, m_nack, m_rdata,
    output gnt, done, rdata, err_nack, err_tmo, m_start, m_addr, m_rw, m_wdata, m_abort
  );

  modport master (
    output req, req_addr, req_rw, req_wdata, m_busy, m_done, m_nack, m_rdata,
    input  gnt, done, rdata, err_nack, err_tmo, m_start, m_addr, m_rw, m_wdata, m_abort
  );
endinterface

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter that shares one I2C master core among NREQ requesters,
// sequencing IDLE -> ISSUE -> WAIT -> RESP with a timeout abort in WAIT.
module i2c_master_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 7,
  parameter int DW      = 8,
  parameter int TIMEOUT = 4096,
  parameter int TW      = 13
) (
  input  logic                   clk,
  input  logic                   reset,
  i2c_master_arbiter_if.slave    bus,
  output logic [1:0]             dbg_state_o
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e          state_q;
  logic [IW-1:0]   last_q;
  logic [IW-1:0]   idx_q;
  logic [TW-1:0]   cnt_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] done_q;
  logic [DW-1:0]   rdata_q;
  logic            err_nack_q;
  logic            err_tmo_q;
  logic            m_start_q;
  logic [AW-1:0]   m_addr_q;
  logic            m_rw_q;
  logic [DW-1:0]   m_wdata_q;
  logic            m_abort_q;

  logic [IW-1:0]   sel_d;
  logic            found_d;

  // First requester with req set, scanning from last_q+1 and wrapping.
  always_comb begin
    found_d = 1'b0;
    sel_d   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found_d && bus.req[(int'(last_q) + k) % NREQ]) begin
        found_d = 1'b1;
        sel_d   = IW'((int'(last_q) + k) % NREQ);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= IW'(NREQ - 1);
      idx_q      <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      rdata_q    <= '0;
      err_nack_q <= 1'b0;
      err_tmo_q  <= 1'b0;
      m_start_q  <= 1'b0;
      m_addr_q   <= '0;
      m_rw_q     <= 1'b0;
      m_wdata_q  <= '0;
      m_abort_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found_d && !bus.m_busy) begin
            idx_q     <= sel_d;
            m_addr_q  <= bus.req_addr[int'(sel_d)*AW +: AW];
            m_rw_q    <= bus.req_rw[sel_d];
            m_wdata_q <= bus.req_wdata[int'(sel_d)*DW +: DW];
            m_start_q <= 1'b1;
            gnt_q     <= NREQ'(1) << sel_d;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          m_start_q <= 1'b0;
          cnt_q     <= '0;
          state_q   <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          // A completion arriving on the timeout cycle takes precedence.
          if (bus.m_done) begin
            done_q     <= gnt_q;
            rdata_q    <= m_rw_q ? bus.m_rdata : '0;
            err_nack_q <= bus.m_nack;
            state_q    <= RESP;
          end else if (cnt_q == TW'(TIMEOUT - 1)) begin
            done_q    <= gnt_q;
            m_abort_q <= 1'b1;
            err_tmo_q <= 1'b1;
            state_q   <= RESP;
          end
        end
        RESP: begin
          done_q     <= '0;
          rdata_q    <= '0;
          err_nack_q <= 1'b0;
          err_tmo_q  <= 1'b0;
          m_abort_q  <= 1'b0;
          gnt_q      <= '0;
          last_q     <= idx_q;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.rdata    = rdata_q;
  assign bus.err_nack = err_nack_q;
  assign bus.err_tmo  = err_tmo_q;
  assign bus.m_start  = m_start_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_rw     = m_rw_q;
  assign bus.m_wdata  = m_wdata_q;
  assign bus.m_abort  = m_abort_q;
  assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter with TIMEOUT=16; inputs are driven and
// outputs sampled on the falling clock edge.
module tb_i2c_master_arbiter;
  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;
  int         cyc;
  int         n_cmp;
  int         n_err;
  logic [10:0] exp_q[$];

  i2c_master_arbiter_if #(.NREQ(4), .AW(7), .DW(8)) bus ();

  i2c_master_arbiter #(
    .NREQ(4), .AW(7), .DW(8), .TIMEOUT(16), .TW(5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_gnt"},      32'(bus.gnt), 0);
    check({tag, "_done"},     32'(bus.done), 0);
    check({tag, "_rdata"},    32'(bus.rdata), 0);
    check({tag, "_err_nack"}, 32'(bus.err_nack), 0);
    check({tag, "_err_tmo"},  32'(bus.err_tmo), 0);
    check({tag, "_m_start"},  32'(bus.m_start), 0);
    check({tag, "_m_abort"},  32'(bus.m_abort), 0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // driver tasks
  task automatic wait_start();
    for (int i = 0; i < 50 && bus.m_start !== 1'b1; i++) step();
    check("m_start_seen", 32'(bus.m_start), 1);
  endtask

  task automatic finish_txn(input int lat, input logic nack, input logic [7:0] rd);
    repeat (lat) step();
    bus.m_done  = 1'b1;
    bus.m_nack  = nack;
    bus.m_rdata = rd;
    step();
    bus.m_done  = 1'b0;
    bus.m_nack  = 1'b0;
    bus.m_rdata = '0;
  endtask

  initial begin
    int t_prev;
    int k;
    logic saw;
    logic [10:0] e;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.req = '0; bus.req_rw = '0;
    bus.req_addr  = {7'h13, 7'h12, 7'h11, 7'h10};
    bus.req_wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.m_busy = 1'b0; bus.m_done = 1'b0; bus.m_nack = 1'b0; bus.m_rdata = '0;
    apply_reset();
    reset = 1'b1;
    step();
    check_quiet("rst");
    check("rst_m_addr",  32'(bus.m_addr), 0);
    check("rst_m_rw",    32'(bus.m_rw), 0);
    check("rst_m_wdata", 32'(bus.m_wdata), 0);
    check("rst_state",   32'(dbg_state), 0);
    reset = 1'b0;
    step();

    // single write from requester 0, completion 10 cycles after m_start
    bus.req_addr[6:0]  = 7'h50;
    bus.req_wdata[7:0] = 8'hA5;
    bus.req = 4'b0001;
    step();
    check("t1_start_lat", 32'(bus.m_start), 1);
    check("t1_gnt",     32'(bus.gnt), 32'h1);
    check("t1_m_addr",  32'(bus.m_addr), 32'h50);
    check("t1_m_wdata", 32'(bus.m_wdata), 32'hA5);
    check("t1_m_rw",    32'(bus.m_rw), 0);
    finish_txn(10, 1'b0, 8'hFF);
    check("t1_done",  32'(bus.done), 32'h1);
    check("t1_rdata", 32'(bus.rdata), 0);
    check("t1_nack",  32'(bus.err_nack), 0);
    check("t1_tmo",   32'(bus.err_tmo), 0);
    bus.req = '0;
    step();
    check("t1_gnt_drop", 32'(bus.gnt), 0);
    check("t1_done_one", 32'(bus.done), 0);

    // round robin from reset: all four requesting, immediate completion
    bus.req_addr = {7'h13, 7'h12, 7'h11, 7'h10};
    apply_reset();
    exp_q.push_back({7'h10, 4'b0001});
    exp_q.push_back({7'h11, 4'b0010});
    exp_q.push_back({7'h12, 4'b0100});
    exp_q.push_back({7'h13, 4'b1000});
    exp_q.push_back({7'h10, 4'b0001});
    bus.req = 4'b1111;
    t_prev = -1;
    for (int n = 0; n < 5; n++) begin
      wait_start();
      e = exp_q.pop_front();
      check("rr_gnt",    32'(bus.gnt), 32'(e[3:0]));
      check("rr_m_addr", 32'(bus.m_addr), 32'(e[10:4]));
      if (t_prev >= 0) check("rr_spacing", 32'(cyc - t_prev), 4);
      t_prev = cyc;
      finish_txn(1, 1'b0, 8'h00);
      check("rr_done",    32'(bus.done), 32'(e[3:0]));
      check("rr_onehot",  32'($countones(bus.done)), 1);
      if (n == 4) bus.req = '0;
    end
    check("rr_queue_empty", 32'(exp_q.size()), 0);

    // read from requester 2 with NACK
    bus.req_rw = 4'b0100;
    bus.req = 4'b0100;
    wait_start();
    check("rd_gnt",  32'(bus.gnt), 32'h4);
    check("rd_m_rw", 32'(bus.m_rw), 1);
    finish_txn(3, 1'b1, 8'h3C);
    check("rd_done",  32'(bus.done), 32'h4);
    check("rd_rdata", 32'(bus.rdata), 32'h3C);
    check("rd_nack",  32'(bus.err_nack), 1);
    check("rd_tmo",   32'(bus.err_tmo), 0);
    bus.req = '0;
    bus.req_rw = '0;
    step();
    check("rd_rdata_clr", 32'(bus.rdata), 0);
    check("rd_nack_clr",  32'(bus.err_nack), 0);

    // timeout: master never completes
    bus.req = 4'b1000;
    wait_start();
    k = 0;
    while (bus.m_abort !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    check("tmo_delay", 32'(k), 17);
    check("tmo_done",  32'(bus.done), 32'h8);
    check("tmo_err",   32'(bus.err_tmo), 1);
    check("tmo_nack",  32'(bus.err_nack), 0);
    bus.req = 4'b0001;
    step();
    check("tmo_abort_one", 32'(bus.m_abort), 0);
    wait_start();
    check("tmo_next_gnt", 32'(bus.gnt), 32'h1);
    finish_txn(1, 1'b0, 8'h00);
    check("tmo_next_done", 32'(bus.done), 32'h1);
    check("tmo_next_err",  32'(bus.err_tmo), 0);

    // m_done on the final timeout cycle wins
    bus.req = 4'b0010;
    wait_start();
    finish_txn(16, 1'b0, 8'h00);
    check("race_done",  32'(bus.done), 32'h2);
    check("race_abort", 32'(bus.m_abort), 0);
    check("race_tmo",   32'(bus.err_tmo), 0);
    bus.req = '0;
    step();

    // m_busy holds off the start
    bus.m_busy = 1'b1;
    bus.req = 4'b0010;
    saw = 1'b0;
    repeat (6) begin
      step();
      saw = saw | bus.m_start;
    end
    check("busy_no_start", 32'(saw), 0);
    bus.m_busy = 1'b0;
    step();
    check("busy_start", 32'(bus.m_start), 1);
    check("busy_gnt",   32'(bus.gnt), 32'h2);
    finish_txn(1, 1'b0, 8'h00);
    check("busy_done", 32'(bus.done), 32'h2);
    bus.req = '0;
    step();

    // reset while in WAIT
    bus.req = 4'b0100;
    wait_start();
    step();
    step();
    check("mid_state_wait", 32'(dbg_state), 2);
    reset = 1'b1;
    step();
    check_quiet("mid_rst");
    check("mid_rst_m_addr", 32'(bus.m_addr), 0);
    check("mid_rst_state",  32'(dbg_state), 0);
    bus.req = 4'b1111;
    reset = 1'b0;
    step();
    check("mid_first_start", 32'(bus.m_start), 1);
    check("mid_first_gnt",   32'(bus.gnt), 32'h1);
    finish_txn(1, 1'b0, 8'h00);
    check("mid_first_done", 32'(bus.done), 32'h1);
    bus.req = '0;
    step();

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
